// File: rtl/bd_horn_pkg.sv
// bd_horn_pkg: shared constants and the leaf table for the Braindrop
// input-horn encoder.
//   NBDin / Npayload / Ncode  - BD word, payload and leaf-code widths
//   leaf_e                    - leaf codes 0..7 (8..15 are invalid)
//   route_bits/route_len      - route prefix (right-justified) and its length
//   chunk_width/chunk_count   - serialization geometry per leaf
// Invalid codes carry zero route length and zero chunk count.
package bd_horn_pkg;

    localparam int NBDin    = 21;
    localparam int Npayload = 48;
    localparam int Ncode    = 4;
    localparam int NLeaf    = 1 << Ncode;

    typedef enum logic [Ncode-1:0] {
        LEAF_RI              = 4'd0,
        LEAF_PROG_AMMM       = 4'd1,
        LEAF_PROG_PAT        = 4'd2,
        LEAF_PROG_TAT0       = 4'd3,
        LEAF_PROG_TAT1       = 4'd4,
        LEAF_NEURON_CONFIG   = 4'd5,
        LEAF_DELAY0          = 4'd6,
        LEAF_TOGGLE_PRE_FIFO = 4'd7
    } leaf_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic [4:0] route_bits [NLeaf] = '{
        5'b00000, 5'b01000, 5'b01001, 5'b10100,
        5'b10101, 5'b01011, 5'b00110, 5'b00111,
        5'b00000, 5'b00000, 5'b00000, 5'b00000,
        5'b00000, 5'b00000, 5'b00000, 5'b00000
    };

    localparam int unsigned route_len [NLeaf] = '{
        1, 4, 4, 5, 5, 4, 3, 3,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    localparam int unsigned chunk_width [NLeaf] = '{
        20, 16, 16, 16, 16, 12, 8, 2,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    localparam int unsigned chunk_count [NLeaf] = '{
        1, 3, 2, 2, 2, 1, 1, 1,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    function automatic logic is_valid_code(input logic [Ncode-1:0] code);
        return chunk_count[code] != 0;
    endfunction

endpackage

// File: rtl/bd_horn_chunk_format.sv
// bd_horn_chunk_format: combinational formatter for one BD input word.
//   code      in  leaf code (valid codes only produce meaningful words)
//   chunk_idx in  index of the chunk to extract from the payload
//   payload   in  right-justified leaf payload
//   word      out route prefix in the MSBs, chunk in the LSBs, zeros between
module bd_horn_chunk_format
    import bd_horn_pkg::*;
(
    input  logic [Ncode-1:0]    code,
    input  logic [1:0]          chunk_idx,
    input  logic [Npayload-1:0] payload,
    output logic [NBDin-1:0]    word
);

    int unsigned          len;
    int unsigned          width;
    logic [NBDin-1:0]     route_w;
    logic [NBDin-1:0]     mask;
    logic [NBDin-1:0]     ones;
    logic [Npayload-1:0]  shifted;

    always_comb begin
        len     = route_len[code];
        width   = chunk_width[code];
        ones    = '1;
        // Route is stored right-justified; left-justify it into the MSBs.
        route_w = NBDin'(route_bits[code]) << (NBDin - len);
        shifted = payload >> (int'(chunk_idx) * width);
        mask    = ~(ones << width);
        word    = route_w | (shifted[NBDin-1:0] & mask);
    end

endmodule

// File: rtl/bd_horn_encoder.sv
// bd_horn_encoder: serializes decoded (leaf code, payload) words into
// Braindrop input-horn words.
//   clk, reset     clock and synchronous active-low reset
//   in_leaf_code   leaf code of the offered word
//   in_payload     right-justified payload
//   in_v / in_a    input valid/ack handshake
//   out_d          BD word (registered)
//   out_v / out_a  output valid/ack handshake (out_v registered)
//   err_invalid    one-cycle pulse after an invalid code is consumed
module bd_horn_encoder #(
    parameter int NBDin    = 21,
    parameter int Npayload = 48,
    parameter int Ncode    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Ncode-1:0]    in_leaf_code,
    input  logic [Npayload-1:0] in_payload,
    input  logic                in_v,
    output logic                in_a,
    output logic [NBDin-1:0]    out_d,
    output logic                out_v,
    input  logic                out_a,
    output logic                err_invalid
);

    import bd_horn_pkg::*;

    state_e              state_q, state_d;
    logic [Ncode-1:0]    code_q, code_d;
    logic [Npayload-1:0] payload_q, payload_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                out_v_q, out_v_d;
    logic [NBDin-1:0]    out_d_q, out_d_d;
    logic                err_q, err_d;
    logic                in_a_c;
    logic                last;
    logic [NBDin-1:0]    fmt_word;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        in_a_c    = 1'b0;
        last      = (cnt_q == 2'(chunk_count[code_q] - 1));

        // in_a is gated by reset so nothing is accepted while reset is held.
        case (state_q)
            ST_IDLE: in_a_c = reset;
            ST_SEND: in_a_c = reset && out_a && last;
            default: in_a_c = 1'b0;
        endcase

        if (state_q == ST_SEND && out_a) begin
            if (!last) begin
                cnt_d = cnt_q + 2'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // A new word accepted on the last-chunk handshake overrides the
        // return to IDLE, giving bubble-free back-to-back transfer.
        if (in_v && in_a_c) begin
            if (is_valid_code(in_leaf_code)) begin
                state_d   = ST_SEND;
                code_d    = in_leaf_code;
                payload_d = in_payload;
                cnt_d     = '0;
            end else begin
                err_d = 1'b1;
            end
        end

        // Outputs are formatted from next-state values so they come straight
        // from flops; during a stall the inputs to the formatter are unchanged.
        out_v_d = (state_d == ST_SEND);
        out_d_d = out_v_d ? fmt_word : '0;
    end

    bd_horn_chunk_format u_fmt (
        .code      (code_d),
        .chunk_idx (cnt_d),
        .payload   (payload_d),
        .word      (fmt_word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            payload_q <= '0;
            cnt_q     <= '0;
            out_v_q   <= 1'b0;
            out_d_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
            out_v_q   <= out_v_d;
            out_d_q   <= out_d_d;
            err_q     <= err_d;
        end
    end

    assign in_a        = in_a_c;
    assign out_v       = out_v_q;
    assign out_d       = out_d_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_bd_horn_encoder.sv
module tb_bd_horn_encoder;

    logic        clk;
    logic        reset;
    logic [3:0]  in_leaf_code;
    logic [47:0] in_payload;
    logic        in_v;
    logic        in_a;
    logic [20:0] out_d;
    logic        out_v;
    logic        out_a;
    logic        err_invalid;

    int checks;
    int errors;

    bd_horn_encoder #(
        .NBDin    (21),
        .Npayload (48),
        .Ncode    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_leaf_code (in_leaf_code),
        .in_payload   (in_payload),
        .in_v         (in_v),
        .in_a         (in_a),
        .out_d        (out_d),
        .out_v        (out_v),
        .out_a        (out_a),
        .err_invalid  (err_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_v = 1'b0; out_a = 1'b0;
        in_leaf_code = '0; in_payload = '0;
        repeat (3) step();
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v: got %b want 0", out_v); end
        checks++; if (out_d !== 21'h0) begin errors++; $display("FAIL reset_out_d: got %h want 000000", out_d); end
        checks++; if (in_a !== 1'b0) begin errors++; $display("FAIL reset_in_a: got %b want 0", in_a); end
        checks++; if (err_invalid !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_invalid); end
        reset = 1'b1;
        #1;
        checks++; if (in_a !== 1'b1) begin errors++; $display("FAIL release_in_a: got %b want 1", in_a); end
    endtask

    task automatic test_ri();
        in_leaf_code = 4'd0; in_payload = 48'h5A5A5; in_v = 1'b1; out_a = 1'b1;
        #1;
        checks++; if (in_a !== 1'b1) begin errors++; $display("FAIL ri_in_a: got %b want 1", in_a); end
        step();
        in_v = 1'b0;
        #1;
        checks++; if (out_v !== 1'b1) begin errors++; $display("FAIL ri_out_v: got %b want 1", out_v); end
        checks++; if (out_d !== 21'h05A5A5) begin errors++; $display("FAIL ri_out_d: got %h want 05a5a5", out_d); end
        step();
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL ri_done: out_v got %b want 0", out_v); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] pay [4] = '{48'h00001, 48'hFFFFF, 48'h80000, 48'h12345};
        logic [20:0] exp [4] = '{21'h000001, 21'h0FFFFF, 21'h080000, 21'h012345};
        in_leaf_code = 4'd0; out_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_payload = pay[i]; in_v = 1'b1;
            #1;
            checks++; if (in_a !== 1'b1) begin errors++; $display("FAIL b2b_in_a[%0d]: got %b want 1", i, in_a); end
            if (i > 0) begin
                checks++; if (out_v !== 1'b1 || out_d !== exp[i-1]) begin
                    errors++; $display("FAIL b2b_word[%0d]: got v=%b d=%h want v=1 d=%h", i-1, out_v, out_d, exp[i-1]);
                end
            end
            step();
        end
        in_v = 1'b0;
        #1;
        checks++; if (out_v !== 1'b1 || out_d !== exp[3]) begin
            errors++; $display("FAIL b2b_word[3]: got v=%b d=%h want v=1 d=%h", out_v, out_d, exp[3]);
        end
        step();
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL b2b_done: out_v got %b want 0", out_v); end
    endtask

    task automatic test_pat_stall();
        in_leaf_code = 4'd2; in_payload = 48'hABCD1234; in_v = 1'b1; out_a = 1'b0;
        #1;
        checks++; if (in_a !== 1'b1) begin errors++; $display("FAIL pat_in_a_idle: got %b want 1", in_a); end
        step();
        // Next word offered immediately; it must wait for the last chunk.
        in_leaf_code = 4'd0; in_payload = 48'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_v !== 1'b1 || out_d !== 21'h121234) begin
                errors++; $display("FAIL pat_stall[%0d]: got v=%b d=%h want v=1 d=121234", i, out_v, out_d);
            end
            checks++; if (in_a !== 1'b0) begin errors++; $display("FAIL pat_stall_in_a[%0d]: got %b want 0", i, in_a); end
            step();
        end
        out_a = 1'b1;
        #1;
        checks++; if (out_d !== 21'h121234 || in_a !== 1'b0) begin
            errors++; $display("FAIL pat_chunk0: got d=%h in_a=%b want d=121234 in_a=0", out_d, in_a);
        end
        step();
        checks++; if (out_v !== 1'b1 || out_d !== 21'h12ABCD || in_a !== 1'b1) begin
            errors++; $display("FAIL pat_chunk1: got v=%b d=%h in_a=%b want v=1 d=12abcd in_a=1", out_v, out_d, in_a);
        end
        step();
        in_v = 1'b0;
        #1;
        checks++; if (out_v !== 1'b1 || out_d !== 21'h000077) begin
            errors++; $display("FAIL pat_next_word: got v=%b d=%h want v=1 d=000077", out_v, out_d);
        end
        step();
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL pat_done: out_v got %b want 0", out_v); end
    endtask

    task automatic test_ammm();
        logic [20:0] exp [3]     = '{21'h1089AB, 21'h104567, 21'h100123};
        logic        exp_ina [3] = '{1'b0, 1'b0, 1'b1};
        in_leaf_code = 4'd1; in_payload = 48'h0123456789AB; in_v = 1'b1; out_a = 1'b1;
        step();
        in_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_v !== 1'b1 || out_d !== exp[i] || in_a !== exp_ina[i]) begin
                errors++; $display("FAIL ammm_chunk[%0d]: got v=%b d=%h in_a=%b want v=1 d=%h in_a=%b",
                                    i, out_v, out_d, in_a, exp[i], exp_ina[i]);
            end
            step();
        end
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL ammm_done: out_v got %b want 0", out_v); end
    endtask

    task automatic test_masking();
        logic [3:0]  codes [3] = '{4'd7, 4'd5, 4'd6};
        logic [47:0] pays  [3] = '{48'hFFFF, 48'hABC123, 48'h1FF};
        logic [20:0] exp   [3] = '{21'h1C0003, 21'h160123, 21'h1800FF};
        out_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_leaf_code = codes[i]; in_payload = pays[i]; in_v = 1'b1;
            step();
            in_v = 1'b0;
            #1;
            checks++; if (out_v !== 1'b1 || out_d !== exp[i]) begin
                errors++; $display("FAIL mask_word[%0d]: got v=%b d=%h want v=1 d=%h", i, out_v, out_d, exp[i]);
            end
            step();
        end
        // TAT0: two 16-bit chunks, payload bits 32 and up ignored.
        in_leaf_code = 4'd3; in_payload = 48'hFFFFBEEFCAFE; in_v = 1'b1;
        step();
        in_v = 1'b0;
        #1;
        checks++; if (out_d !== 21'h14CAFE) begin errors++; $display("FAIL tat0_chunk0: got %h want 14cafe", out_d); end
        step();
        checks++; if (out_d !== 21'h14BEEF) begin errors++; $display("FAIL tat0_chunk1: got %h want 14beef", out_d); end
        step();
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL tat0_done: out_v got %b want 0", out_v); end
    endtask

    task automatic test_invalid();
        in_leaf_code = 4'd12; in_payload = 48'h1234; in_v = 1'b1; out_a = 1'b1;
        #1;
        checks++; if (in_a !== 1'b1) begin errors++; $display("FAIL inv_in_a: got %b want 1", in_a); end
        step();
        in_v = 1'b0;
        #1;
        checks++; if (err_invalid !== 1'b1 || out_v !== 1'b0 || in_a !== 1'b1) begin
            errors++; $display("FAIL inv_pulse: got err=%b v=%b in_a=%b want err=1 v=0 in_a=1", err_invalid, out_v, in_a);
        end
        step();
        checks++; if (err_invalid !== 1'b0 || out_v !== 1'b0) begin
            errors++; $display("FAIL inv_end: got err=%b v=%b want err=0 v=0", err_invalid, out_v);
        end
        // Two invalid words back to back: one pulse cycle each.
        in_leaf_code = 4'd9; in_v = 1'b1;
        step();
        in_leaf_code = 4'd15;
        #1;
        checks++; if (err_invalid !== 1'b1) begin errors++; $display("FAIL inv_b2b_first: got %b want 1", err_invalid); end
        step();
        in_v = 1'b0;
        #1;
        checks++; if (err_invalid !== 1'b1 || out_v !== 1'b0) begin
            errors++; $display("FAIL inv_b2b_second: got err=%b v=%b want err=1 v=0", err_invalid, out_v);
        end
        step();
        checks++; if (err_invalid !== 1'b0) begin errors++; $display("FAIL inv_b2b_end: got %b want 0", err_invalid); end
    endtask

    task automatic test_reset_midword();
        in_leaf_code = 4'd1; in_payload = 48'h0123456789AB; in_v = 1'b1; out_a = 1'b1;
        step();
        in_v = 1'b0;
        #1;
        checks++; if (out_d !== 21'h1089AB) begin errors++; $display("FAIL rmw_chunk0: got %h want 1089ab", out_d); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (in_a !== 1'b0) begin errors++; $display("FAIL rmw_in_a_in_reset: got %b want 0", in_a); end
        step();
        checks++; if (out_v !== 1'b0 || out_d !== 21'h0) begin
            errors++; $display("FAIL rmw_flushed: got v=%b d=%h want v=0 d=000000", out_v, out_d);
        end
        reset = 1'b1;
        in_leaf_code = 4'd0; in_payload = 48'h42; in_v = 1'b1;
        #1;
        checks++; if (in_a !== 1'b1) begin errors++; $display("FAIL rmw_release_in_a: got %b want 1", in_a); end
        step();
        in_v = 1'b0;
        #1;
        checks++; if (out_v !== 1'b1 || out_d !== 21'h000042) begin
            errors++; $display("FAIL rmw_new_word: got v=%b d=%h want v=1 d=000042", out_v, out_d);
        end
        step();
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL rmw_no_stale: out_v got %b want 0", out_v); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ri();
        test_back_to_back();
        test_pat_stall();
        test_ammm();
        test_masking();
        test_invalid();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
